// File: rtl/risc_spm_control_unit.sv
// Sequencing FSM for the 8-bit RISC stored-program machine: one datapath micro-step per clock.
// Outputs are decoded combinationally from the current state, the instruction register and Zflag.
module risc_spm_control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instruction,
    input  logic       Zflag,
    output logic       Load_R0,
    output logic       Load_R1,
    output logic       Load_R2,
    output logic       Load_R3,
    output logic       Load_PC,
    output logic       Inc_PC,
    output logic       Load_IR,
    output logic       Load_Add_R,
    output logic       Load_Reg_Y,
    output logic       Load_Reg_Z,
    output logic [2:0] Sel_Bus_1_Mux,
    output logic [1:0] Sel_Bus_2_Mux,
    output logic       write,
    output logic       halted,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_e;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    localparam logic [2:0] SEL1_PC  = 3'd4;
    localparam logic [1:0] SEL2_ALU = 2'd0;
    localparam logic [1:0] SEL2_B1  = 2'd1;
    localparam logic [1:0] SEL2_MEM = 2'd2;

    state_e     state_q, state_d;
    logic [3:0] opcode;
    logic [1:0] src, dest;
    logic [3:0] load_r;

    assign opcode = instruction[7:4];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and micro-step decode.
    always_comb begin
        state_d       = state_q;
        load_r        = 4'b0000;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        Sel_Bus_1_Mux = 3'd0;
        Sel_Bus_2_Mux = SEL2_ALU;
        write         = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_idle: state_d = S_fet1;
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_B1;
                Load_Add_R    = 1'b1;
                state_d       = S_fet2;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = S_dec;
            end
            S_dec: begin
                // Unknown opcode bits fall through to the illegal branch.
                case (opcode)
                    OP_NOP: state_d = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = {1'b0, src};
                        Sel_Bus_2_Mux = SEL2_B1;
                        Load_Reg_Y    = 1'b1;
                        state_d       = S_ex1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = {1'b0, src};
                        Sel_Bus_2_Mux = SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        load_r[dest]  = 1'b1;
                        state_d       = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = SEL1_PC;
                        Sel_Bus_2_Mux = SEL2_B1;
                        Load_Add_R    = 1'b1;
                        state_d       = (opcode == OP_RD) ? S_rd1 :
                                        (opcode == OP_WR) ? S_wr1 : S_br1;
                    end
                    OP_BRZ: begin
                        if (Zflag == 1'b1) begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_B1;
                            Load_Add_R    = 1'b1;
                            state_d       = S_br1;
                        end else begin
                            Inc_PC  = 1'b1;
                            state_d = S_fet1;
                        end
                    end
                    default: state_d = HALT_ON_ILLEGAL ? S_halt : S_fet1;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = {1'b0, dest};
                Sel_Bus_2_Mux = SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                load_r[dest]  = 1'b1;
                state_d       = S_fet1;
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = (state_q == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                load_r[dest]  = 1'b1;
                state_d       = S_fet1;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = {1'b0, src};
                write         = 1'b1;
                state_d       = S_fet1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                state_d       = S_br2;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
                state_d       = S_fet1;
            end
            S_halt: begin
                halted  = 1'b1;
                state_d = S_halt;
            end
            default: state_d = S_idle;
        endcase
    end

    assign Load_R0 = load_r[0];
    assign Load_R1 = load_r[1];
    assign Load_R2 = load_r[2];
    assign Load_R3 = load_r[3];
    assign state   = state_q;

endmodule

// File: tb/tb_risc_spm_control_unit.sv
// Directed-vector bench for risc_spm_control_unit: checks state code and every control output each cycle.
module tb_risc_spm_control_unit;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_FET1 = 4'd1;
    localparam logic [3:0] ST_FET2 = 4'd2;
    localparam logic [3:0] ST_DEC  = 4'd3;
    localparam logic [3:0] ST_EX1  = 4'd4;
    localparam logic [3:0] ST_RD1  = 4'd5;
    localparam logic [3:0] ST_RD2  = 4'd6;
    localparam logic [3:0] ST_WR1  = 4'd7;
    localparam logic [3:0] ST_WR2  = 4'd8;
    localparam logic [3:0] ST_BR1  = 4'd9;
    localparam logic [3:0] ST_BR2  = 4'd10;
    localparam logic [3:0] ST_HALT = 4'd11;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       Zflag;
    logic       Load_R0, Load_R1, Load_R2, Load_R3;
    logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
    logic [2:0] Sel_Bus_1_Mux;
    logic [1:0] Sel_Bus_2_Mux;
    logic       write, halted;
    logic [3:0] state;
    logic [16:0] outs;

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    risc_spm_control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
        .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
        .Load_PC(Load_PC), .Inc_PC(Inc_PC), .Load_IR(Load_IR), .Load_Add_R(Load_Add_R),
        .Load_Reg_Y(Load_Reg_Y), .Load_Reg_Z(Load_Reg_Z),
        .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
        .write(write), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    assign outs = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Load_IR, Load_Add_R,
                   Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, write, halted};

    // Build an expected output vector in the same packing as outs.
    function automatic logic [16:0] mk(input logic [3:0] lr, input logic pc, input logic inc,
                                       input logic ir, input logic ar, input logic y,
                                       input logic z, input logic [2:0] s1, input logic [1:0] s2,
                                       input logic wr, input logic h);
        return {lr, pc, inc, ir, ar, y, z, s1, s2, wr, h};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [16:0] ov);
        #1;
        check_eq({tag, "_state"}, 32'(state), 32'(st));
        check_eq({tag, "_outs"}, 32'(outs), 32'(ov));
    endtask

    // Runs the two fetch cycles for ins; leaves the FSM in S_dec.
    task automatic fetch(input string tag, input logic [7:0] ins);
        instruction = ins;
        expect_cycle({tag, "_fet1"}, ST_FET1, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
        tick();
        expect_cycle({tag, "_fet2"}, ST_FET2, mk(4'b0, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        instruction = 8'h00;
        Zflag = 1'b0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_cycle("reset", ST_IDLE, 17'd0);
        end
        rst = 1'b0;
        expect_cycle("idle", ST_IDLE, 17'd0);
        tick();

        // Instruction changes in S_fet1 must not disturb outputs.
        instruction = 8'hA5;
        expect_cycle("fet1_insn_change", ST_FET1, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));

        // ADD R1 -> R2
        fetch("add", 8'h16);
        expect_cycle("add_dec", ST_DEC, mk(4'b0, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 0));
        tick();
        expect_cycle("add_ex1", ST_EX1, mk(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
        tick();

        // RD -> R3
        fetch("rd", 8'h53);
        expect_cycle("rd_dec", ST_DEC, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
        tick();
        expect_cycle("rd_rd1", ST_RD1, mk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        tick();
        expect_cycle("rd_rd2", ST_RD2, mk(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
        tick();

        // WR from R1; write is a single-cycle strobe.
        fetch("wr", 8'h64);
        expect_cycle("wr_dec", ST_DEC, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
        tick();
        expect_cycle("wr_wr1", ST_WR1, mk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        tick();
        expect_cycle("wr_wr2", ST_WR2, mk(4'b0, 0, 0, 0, 0, 0, 0, 3'd1, 2'd0, 1, 0));
        tick();
        check_eq("wr_strobe_end", 32'(write), 32'd0);

        // BRZ not taken
        Zflag = 1'b0;
        fetch("brz0", 8'h80);
        expect_cycle("brz0_dec", ST_DEC, mk(4'b0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
        tick();

        // BRZ taken; Zflag outside S_dec is ignored.
        fetch("brz1", 8'h80);
        Zflag = 1'b1;
        expect_cycle("brz1_dec", ST_DEC, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
        tick();
        Zflag = 1'b0;
        expect_cycle("brz1_br1", ST_BR1, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        tick();
        expect_cycle("brz1_br2", ST_BR2, mk(4'b0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
        tick();

        // NOT src=R2 dest=R3
        fetch("not", 8'h4B);
        expect_cycle("not_dec", ST_DEC, mk(4'b1000, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
        tick();

        // NOP
        fetch("nop", 8'h00);
        expect_cycle("nop_dec", ST_DEC, 17'd0);
        tick();

        // Reset during S_rd1 aborts the RD with no register load.
        fetch("rdrst", 8'h53);
        tick();
        expect_cycle("rdrst_rd1", ST_RD1, mk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        rst = 1'b1;
        tick();
        expect_cycle("rdrst_idle", ST_IDLE, 17'd0);
        rst = 1'b0;
        tick();

        // Illegal opcode halts until reset.
        fetch("ill", 8'hF0);
        expect_cycle("ill_dec", ST_DEC, 17'd0);
        for (int i = 0; i < 22; i++) begin
            tick();
            expect_cycle("ill_halt", ST_HALT, mk(4'b0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1));
        end
        rst = 1'b1;
        tick();
        expect_cycle("halt_rst", ST_IDLE, 17'd0);
        rst = 1'b0;
        tick();
        expect_cycle("post_rst_fet1", ST_FET1, mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
